// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU controller: accepts one W-bit operation and steps a single
// one-bit ALU slice across the operands, LSB first, one bit per clock.
module alu_serial_sequencer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_valid_i,
  output logic         start_ready_o,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         cout_o,
  output logic         zero_o,
  output logic         err_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastBit = CW'(W - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  r_sh_q, r_sh_d;
  logic [2:0]    op_q, op_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic a_bit, b_bit, is_arith, is_invalid, slice_bit, slice_carry;
  logic accept;

  // One-bit ALU slice; SUB reuses the adder with B inverted and carry-in 1.
  always_comb begin
    a_bit       = a_sh_q[0];
    b_bit       = (op_q == OpSub) ? ~b_sh_q[0] : b_sh_q[0];
    is_arith    = (op_q == OpAdd) || (op_q == OpSub);
    is_invalid  = (op_q == 3'b110) || (op_q == 3'b111);
    slice_bit   = 1'b0;
    slice_carry = carry_q;
    case (op_q)
      OpAdd, OpSub: begin
        slice_bit   = a_bit ^ b_bit ^ carry_q;
        slice_carry = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
      end
      OpAnd:   slice_bit = a_bit & b_bit;
      OpOr:    slice_bit = a_bit | b_bit;
      OpXor:   slice_bit = a_bit ^ b_bit;
      OpNot:   slice_bit = ~a_bit;
      default: slice_bit = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) && start_valid_i;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          r_sh_d  = '0;
          op_d    = op_i;
          carry_d = (op_i == OpSub);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = {1'b0, a_sh_q[W-1:1]};
        b_sh_d  = {1'b0, b_sh_q[W-1:1]};
        r_sh_d  = {slice_bit, r_sh_q[W-1:1]};
        carry_d = slice_carry;
        cnt_d   = cnt_q + CntOne;
        // Publish on the same edge that shifts in the last bit.
        if (cnt_q == LastBit) begin
          state_d  = StDone;
          result_d = r_sh_d;
          cout_d   = is_arith ? slice_carry : 1'b0;
          zero_d   = (r_sh_d == '0);
          err_d    = is_invalid;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q == StRun) || (state_q == StDone);
  assign done_o        = (state_q == StDone);
  assign result_o      = result_q;
  assign cout_o        = cout_q;
  assign zero_o        = zero_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: a transaction-level model
// predicts every output each cycle, with directed literal scenarios on top.
module tb_alu_serial_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstN;
  logic         startValid;
  logic         startReadyO;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] resultO;
  logic         coutO, zeroO, errO, busyO, doneO;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  int           mLeft = 0;
  logic [W-1:0] mRes = '0, pRes = '0;
  logic         mCout = 1'b0, mZero = 1'b0, mErr = 1'b0;
  logic         pCout = 1'b0, pErr = 1'b0;

  alu_serial_sequencer #(.W(W)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_valid_i(startValid),
    .start_ready_o(startReadyO), .op_i(op), .a_i(a), .b_i(b),
    .result_o(resultO), .cout_o(coutO), .zero_o(zeroO), .err_o(errO),
    .busy_o(busyO), .done_o(doneO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for one whole operation.
  function automatic void computeOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] r, output logic c, output logic e);
    logic [W:0] s;
    r = '0;
    c = 1'b0;
    e = 1'b0;
    case (o)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      3'd1: begin s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1); r = s[W-1:0]; c = s[W]; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~x;
      default: e = 1'b1;
    endcase
  endfunction

  // Model: an accepted op keeps the block busy for W+1 cycles, the last of which is done.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mLeft = 0;
      mRes  = '0;
      mCout = 1'b0;
      mZero = 1'b0;
      mErr  = 1'b0;
    end else if (mLeft == 0) begin
      if (startValid === 1'b1) begin
        mLeft = W + 1;
        computeOp(op, a, b, pRes, pCout, pErr);
      end
    end else begin
      mLeft--;
      if (mLeft == 1) begin
        mRes  = pRes;
        mCout = pCout;
        mZero = (pRes == '0);
        mErr  = pErr;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("start_ready", startReadyO, mLeft == 0);
      checkOutput("busy", busyO, mLeft != 0);
      checkOutput("done", doneO, mLeft == 1);
      checkOutput("result", resultO, mRes);
      checkOutput("cout", coutO, mCout);
      checkOutput("zero", zeroO, mZero);
      checkOutput("err", errO, mErr);
    end
  end

  // Issue one op when ready, scramble inputs after accept, return accept-to-done edge count.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    int guard = 0;
    lat = 0;
    @(negedge clk);
    while (!startReadyO && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!startReadyO) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    startValid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    startValid = 1'b0;
    op = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (doneO) return;
    end
    checkOutput("done_timeout", 0, 1);
  endtask

  task automatic expectOut(input string name, input logic [W-1:0] r, input logic c, input logic z, input logic e);
    checkOutput({name, "_result"}, resultO, r);
    checkOutput({name, "_cout"}, coutO, c);
    checkOutput({name, "_zero"}, zeroO, z);
    checkOutput({name, "_err"}, errO, e);
  endtask

  initial begin
    int lat;
    int guard;
    logic [W-1:0] r;
    logic c, e;

    startValid = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    expectOut("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_ready", startReadyO, 1);
    checkOutput("reset_busy", busyO, 0);
    checkOutput("reset_done", doneO, 0);

    computeOp(3'b001, 4'b0011, 4'b0101, r, c, e);
    checkOutput("model_sub", {e, c, r}, 6'b001110);
    computeOp(3'b000, 4'b1111, 4'b0001, r, c, e);
    checkOutput("model_add_wrap", {e, c, r}, 6'b010000);

    @(negedge clk);
    rstN = 1'b1;
    checkEn = 1'b1;

    applyStimulus(3'b000, 4'b0111, 4'b0101, lat);
    checkOutput("add_latency", lat, W);
    expectOut("add", 4'b1100, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 4'b1111, 4'b0001, lat);
    expectOut("add_wrap", 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b001, 4'b0011, 4'b0101, lat);
    expectOut("sub_borrow", 4'b1110, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 4'b0101, 4'b0101, lat);
    expectOut("sub_equal", 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b010, 4'b1100, 4'b1010, lat);
    expectOut("and", 4'b1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b011, 4'b1100, 4'b1010, lat);
    expectOut("or", 4'b1110, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 4'b1100, 4'b1010, lat);
    expectOut("xor", 4'b0110, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b101, 4'b1100, 4'b1010, lat);
    expectOut("not", 4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b111, 4'b1100, 4'b1010, lat);
    expectOut("invalid", 4'b0000, 1'b0, 1'b1, 1'b1);

    // Back-to-back: valid held high, inputs scrambled while busy.
    @(negedge clk);
    startValid = 1'b1;
    op = 3'b000;
    a = 4'b0011;
    b = 4'b0001;
    @(posedge clk);
    guard = 0;
    @(negedge clk);
    while (!doneO && guard < 20) begin
      op = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_first_done", doneO, 1);
    expectOut("b2b_first", 4'b0100, 1'b0, 1'b0, 1'b0);
    op = 3'b100;
    a = 4'b1100;
    b = 4'b1010;
    lat = 0;
    @(posedge clk);
    lat++;
    @(negedge clk);
    checkOutput("b2b_idle_ready", startReadyO, 1);
    checkOutput("b2b_hold_result", resultO, 4'b0100);
    @(posedge clk);
    lat++;
    #1 startValid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!doneO && guard < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_done_to_done", lat, W + 2);
    expectOut("b2b_second", 4'b0110, 1'b0, 1'b0, 1'b0);

    // Reset two cycles into an ADD.
    @(negedge clk);
    startValid = 1'b1;
    op = 3'b000;
    a = 4'b1111;
    b = 4'b0001;
    @(posedge clk);
    #1 startValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    expectOut("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_reset_ready", startReadyO, 1);
    checkOutput("mid_reset_busy", busyO, 0);
    checkOutput("mid_reset_done", doneO, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    applyStimulus(3'b001, 4'b0101, 4'b0011, lat);
    checkOutput("post_reset_latency", lat, W);
    expectOut("post_reset_sub", 4'b0010, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), lat);
      checkOutput("rand_latency", lat, W);
    end

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial ALU controller. It accepts one W-bit operation through a valid/ready handshake and steps the shared one-bit ALU slice (full adder, AND, OR, XOR, NOT) across the operand bits, LSB first, one bit per clock. It holds the carry between bits in a flip-flop and assembles the result in a shift register. It sits between the operation issuer and the bit-level ALU cells, so W-bit arithmetic runs on a single slice.

## Interface
- W, default 4: operand/result width; legal range W >= 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst = 0 resets).
- start_valid  in  1  issuer presents an operation.
- start_ready  out  1  block can accept; equals (state == IDLE).
- op  in  3  operation code:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a.
  - 110 and 111 are invalid.
- a  in  W  operand A, sampled on accept.
- b  in  W  operand B, sampled on accept.
- result  out  W  registered result, held until the next completion.
- cout  out  1  final carry for ADD/SUB; 0 for logic ops and invalid ops.
- zero  out  1  registered (result == 0).
- err  out  1  registered; 1 if the last completed op was invalid.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE; outputs are valid from this cycle.

## Operation
- **Reset** (rst low, asynchronous): takes effect immediately, also mid-operation, and aborts any operation in progress.
  - State = IDLE.
  - result, cout, zero, err, done, busy = 0; start_ready = 1.
  - Shift registers, carry flip-flop and bit counter = 0.
- **IDLE:**
  - Accept happens on a rising edge with start_valid & start_ready.
  - On accept: load A_sh = a, B_sh = b, op_r = op.
  - carry = 1 for SUB, else 0. bit counter = 0. Next state RUN.
- **RUN** (exactly W cycles): each cycle works on bit i = A_sh[0], B_sh[0].
  - ADD: bit = a_i ^ b_i ^ carry; carry <= majority(a_i, b_i, carry).
  - SUB: same as ADD with b_i inverted. Computes a + ~b + 1; cout = 1 means no borrow (a >= b).
  - AND / OR / XOR: bitwise; carry unchanged.
  - NOT: bit = ~a_i.
  - Invalid op: bit = 0.
  - Each cycle: A_sh and B_sh shift right; R_sh shifts right with the new bit entering at the MSB; counter increments.
  - When counter == W-1: next state DONE.
  - Also on that edge: result <= final R_sh, cout <= carry (ADD/SUB only), zero, err.
- **DONE** (1 cycle): done = 1. Next state IDLE unconditionally.
- **Accept rules:**
  - start_valid while busy is ignored. No queueing; the issuer must hold start_valid until it sees ready.
  - Operands and op may change freely after accept without affecting the running op.
- **Width:** the bit counter is ceil(log2 W) bits. Carry out of the MSB appears only on cout. No overflow flag.

## Timing
- Accept at edge E0. RUN occupies the cycles after E0 through EW. State enters DONE at edge EW.
- done is high for the cycle between EW and EW+1.
- start_ready returns high after EW+1.
- Latency from accept edge to done: W edges.
- Throughput: one op per W+2 cycles.
- result, cout, zero, err change only at the DONE-entry edge or on reset. They are stable between completions.
- Reset mid-RUN: no partial result is ever published. The next op after release starts with a clean carry.
- start_valid asserted in the DONE cycle: not accepted, because start_ready = 0. Accepted at the first edge in IDLE.

## Test plan
All scenarios use W = 4.
1. **ADD, no carry:** 0111 + 0101 -> result 1100, cout 0, zero 0, err 0. done exactly 4 edges after accept, high for one cycle.
2. **ADD, wrap-around:** 1111 + 0001 -> result 0000, cout 1, zero 1.
3. **SUB:**
   - 0011 - 0101 -> result 1110, cout 0.
   - 0101 - 0101 -> result 0000, cout 1, zero 1.
4. **Logic ops** with a = 1100, b = 1010:
   - AND -> 1000, OR -> 1110, XOR -> 0110, NOT -> 0011.
   - cout 0 for all four.
   - op 111 -> result 0000, err 1, zero 1.
5. **Back-to-back:**
   - Hold start_valid high and change a/b/op while busy.
   - Required: the second op is accepted only at the first IDLE edge after done.
   - Required: the first result holds until the second DONE-entry edge.
6. **Reset mid-operation:**
   - Pull rst low 2 cycles into an ADD of 1111 + 0001.
   - Required: all outputs 0 immediately and start_ready = 1.
   - After release, SUB 0101 - 0011 -> result 0010, cout 1.
